stream_demux_1_4: RTL



---
 rtl/stream_demux_pkg.sv | 11 +
 rtl/demux_out_slot.sv | 51 +++++
 rtl/stream_demux_1_4.sv | 67 ++++++
 3 files changed

// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
package stream_demux_pkg;

    localparam int N_OUT = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/demux_out_slot.sv
// One output channel: single-entry holding register with valid flag.
// Optional saturating pop counter is built when STREAM_DEMUX_CNT_EN is defined.
module demux_out_slot
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             pop_ready,
    input  logic [WIDTH-1:0] din,
    output logic             valid,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] cnt
);

    logic pop;

    // A ready consumer only completes a transfer when a beat is actually held.
    assign pop = valid & pop_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

`ifdef STREAM_DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (pop && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;
`else
    assign cnt = '0;
`endif

endmodule

// File: rtl/stream_demux_1_4.sv
// 1-to-4 valid/ready stream demultiplexer with one holding register per channel.
// Optional per-channel transfer counters enabled by STREAM_DEMUX_CNT_EN.
module stream_demux_1_4
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [N_OUT-1:0] out_valid,
    input  logic [N_OUT-1:0] out_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
);

    logic [N_OUT-1:0] sel_oh;
    logic [N_OUT-1:0] load;
    logic             acc;
    logic [WIDTH-1:0] dout [N_OUT];
    logic [CNT_W-1:0] cnt  [N_OUT];

    assign sel_oh[0] = ~in_sel[1] & ~in_sel[0];
    assign sel_oh[1] = ~in_sel[1] &  in_sel[0];
    assign sel_oh[2] =  in_sel[1] & ~in_sel[0];
    assign sel_oh[3] =  in_sel[1] &  in_sel[0];

    // Ready depends only on the addressed channel: empty, or draining this cycle.
    assign in_ready = |(sel_oh & (~out_valid | out_ready));
    assign acc      = in_valid & in_ready;
    assign load     = {N_OUT{acc}} & sel_oh;

    for (genvar i = 0; i < N_OUT; i++) begin : g_slot
        demux_out_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load[i]),
            .pop_ready(out_ready[i]),
            .din      (in_data),
            .valid    (out_valid[i]),
            .dout     (dout[i]),
            .cnt      (cnt[i])
        );
    end

    assign out_data0 = dout[0];
    assign out_data1 = dout[1];
    assign out_data2 = dout[2];
    assign out_data3 = dout[3];

    assign cnt0 = cnt[0];
    assign cnt1 = cnt[1];
    assign cnt2 = cnt[2];
    assign cnt3 = cnt[3];

endmodule
